// File: rtl/opk_pkg.sv
// Shared constants and FSM encoding for the one-shot key pulse generator and monitor.
package opk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } opk_state_e;

  localparam int unsigned DEFAULT_MIN_GAP = 100;
  // Generator block length; equals the monitor's default dead time.
  localparam int unsigned GEN_BLOCK_LEN   = 100;

endpackage

// File: rtl/opk_sync.sv
// Input synchronizer chain; every stage resets to the line's idle level (1).
module opk_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_o = sync_q[STAGES-1];

endmodule

// File: rtl/opk_pulse_monitor.sv
// Measures width and preceding gap of active-low pulses on the one-shot key line,
// counts pulses and keeps sticky flags for over-wide pulses and short dead times.
module opk_pulse_monitor
  import opk_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MIN_GAP     = DEFAULT_MIN_GAP,
  parameter int unsigned MAX_WIDTH   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_n,
  input  logic             clr,
  output logic [CNT_W-1:0] pulse_count,
  output logic [CNT_W-1:0] width_last,
  output logic [CNT_W-1:0] gap_last,
  output logic             gap_valid,
  output logic             meas_valid,
  output logic             err_gap,
  output logic             err_width,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  opk_state_e       state_q, state_d;
  logic             s, s_d_q;
  logic             fall, rise;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] pend_gap_q, pend_gap_d;
  logic             pend_gv_q, pend_gv_d;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_d;
  logic [CNT_W-1:0] width_last_q, width_last_d;
  logic [CNT_W-1:0] gap_last_q, gap_last_d;
  logic             gap_valid_q, gap_valid_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_gap_q, err_gap_d;
  logic             err_width_q, err_width_d;
  logic             busy_q, busy_d;

  opk_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pulse_n),
    .s_o (s)
  );

  assign fall = s_d_q & ~s;
  assign rise = ~s_d_q & s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      s_d_q         <= 1'b1;
      width_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      pend_gap_q    <= '0;
      pend_gv_q     <= 1'b0;
      pulse_count_q <= '0;
      width_last_q  <= '0;
      gap_last_q    <= '0;
      gap_valid_q   <= 1'b0;
      meas_valid_q  <= 1'b0;
      err_gap_q     <= 1'b0;
      err_width_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_d_q         <= s;
      width_cnt_q   <= width_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      pend_gap_q    <= pend_gap_d;
      pend_gv_q     <= pend_gv_d;
      pulse_count_q <= pulse_count_d;
      width_last_q  <= width_last_d;
      gap_last_q    <= gap_last_d;
      gap_valid_q   <= gap_valid_d;
      meas_valid_q  <= meas_valid_d;
      err_gap_q     <= err_gap_d;
      err_width_q   <= err_width_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    width_cnt_d   = width_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    pend_gap_d    = pend_gap_q;
    pend_gv_d     = pend_gv_q;
    width_last_d  = width_last_q;
    gap_last_d    = gap_last_q;
    gap_valid_d   = gap_valid_q;
    meas_valid_d  = 1'b0;
    // clr is applied first so a coincident fall or error still lands afterwards.
    pulse_count_d = clr ? '0 : pulse_count_q;
    err_gap_d     = clr ? 1'b0 : err_gap_q;
    err_width_d   = clr ? 1'b0 : err_width_q;

    unique case (state_q)
      ST_IDLE, ST_HIGH: begin
        if (fall) begin
          state_d       = ST_LOW;
          width_cnt_d   = CNT_W'(1);
          pulse_count_d = pulse_count_d + CNT_W'(1);
          pend_gap_d    = gap_cnt_q;
          pend_gv_d     = (state_q == ST_HIGH);
          if ((state_q == ST_HIGH) && (gap_cnt_q < CNT_W'(MIN_GAP))) begin
            err_gap_d = 1'b1;
          end
        end else if ((state_q == ST_HIGH) && (gap_cnt_q != CNT_MAX)) begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d      = ST_HIGH;
          width_last_d = width_cnt_q;
          gap_last_d   = pend_gap_q;
          gap_valid_d  = pend_gv_q;
          meas_valid_d = 1'b1;
          gap_cnt_d    = CNT_W'(1);
          if (width_cnt_q > CNT_W'(MAX_WIDTH)) begin
            err_width_d = 1'b1;
          end
        end else if (width_cnt_q != CNT_MAX) begin
          width_cnt_d = width_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_LOW);
  end

  assign pulse_count = pulse_count_q;
  assign width_last  = width_last_q;
  assign gap_last    = gap_last_q;
  assign gap_valid   = gap_valid_q;
  assign meas_valid  = meas_valid_q;
  assign err_gap     = err_gap_q;
  assign err_width   = err_width_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_opk_pulse_monitor.sv
// Directed bench for opk_pulse_monitor with hand-computed expectations.
module tb_opk_pulse_monitor;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             pulse_n;
  logic             clr;
  logic [CNT_W-1:0] pulse_count, width_last, gap_last;
  logic             gap_valid, meas_valid, err_gap, err_width, busy;

  int n_asserts = 0;
  int n_fails   = 0;
  int meas_cnt  = 0;
  logic [CNT_W-1:0] cap_width, cap_gap;
  logic             cap_gv;

  opk_pulse_monitor #(
    .CNT_W(CNT_W), .MIN_GAP(100), .MAX_WIDTH(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .pulse_n(pulse_n), .clr(clr),
    .pulse_count(pulse_count), .width_last(width_last), .gap_last(gap_last),
    .gap_valid(gap_valid), .meas_valid(meas_valid), .err_gap(err_gap),
    .err_width(err_width), .busy(busy)
  );

  always #5 clk = ~clk;

  // Capture every measurement strobe just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (meas_valid === 1'b1) begin
      meas_cnt  = meas_cnt + 1;
      cap_width = width_last;
      cap_gap   = gap_last;
      cap_gv    = gap_valid;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_low(input int n);
    pulse_n = 1'b0;
    cyc(n);
    pulse_n = 1'b1;
  endtask

  task automatic wait_meas(input string tag, input int target);
    int k = 0;
    while (meas_cnt < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(meas_cnt >= target), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  int base;
  logic ok_idle;

  initial begin
    rst = 1'b1; pulse_n = 1'b1; clr = 1'b0;
    cyc(1);
    do_reset();

    // Idle after reset: everything stays zero for 50 cycles.
    ok_idle = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if ({pulse_count, width_last, gap_last, gap_valid, meas_valid,
           err_gap, err_width, busy} !== '0) ok_idle = 1'b0;
    end
    check("idle_outputs_zero", 64'(ok_idle), 64'd1);

    // Single 1-cycle pulse: count appears SYNC_STAGES+1 edges after the drive.
    base = meas_cnt;
    drive_low(1);
    cyc(1);
    check("p1_count_not_yet", 64'(pulse_count), 64'd0);
    cyc(1);
    check("p1_count", 64'(pulse_count), 64'd1);
    check("p1_busy", 64'(busy), 64'd1);
    wait_meas("p1_meas_timeout", base + 1);
    check("p1_width", 64'(cap_width), 64'd1);
    check("p1_gv", 64'(cap_gv), 64'd0);
    check("p1_errs", 64'({err_gap, err_width}), 64'd0);
    cyc(5);
    check("p1_one_strobe", 64'(meas_cnt - base), 64'd1);
    check("p1_not_busy", 64'(busy), 64'd0);

    // Two pulses 150 high cycles apart.
    do_reset();
    base = meas_cnt;
    drive_low(1);
    cyc(150);
    drive_low(1);
    wait_meas("g150_meas_timeout", base + 2);
    check("g150_gap", 64'(cap_gap), 64'd150);
    check("g150_gv", 64'(cap_gv), 64'd1);
    check("g150_err_gap", 64'(err_gap), 64'd0);
    check("g150_count", 64'(pulse_count), 64'd2);

    // Short gap then over-wide pulse, then clr.
    do_reset();
    base = meas_cnt;
    drive_low(1);
    cyc(40);
    drive_low(1);
    cyc(2);
    check("g40_err_gap", 64'(err_gap), 64'd1);
    check("g40_err_width_clean", 64'(err_width), 64'd0);
    cyc(10);
    drive_low(3);
    wait_meas("w3_meas_timeout", base + 3);
    check("w3_width", 64'(cap_width), 64'd3);
    check("w3_err_width", 64'(err_width), 64'd1);
    check("w3_count", 64'(pulse_count), 64'd3);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("clr_flags", 64'({err_gap, err_width}), 64'd0);
    check("clr_count", 64'(pulse_count), 64'd0);

    // clr in the fall cycle, also coinciding with a short-gap error.
    cyc(120);
    drive_low(1);
    cyc(2);
    check("pa_count", 64'(pulse_count), 64'd1);
    check("pa_err_gap", 64'(err_gap), 64'd0);
    cyc(5);
    drive_low(1);
    cyc(1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("clr_fall_count", 64'(pulse_count), 64'd1);
    check("clr_fall_err_gap", 64'(err_gap), 64'd1);

    // Back-to-back 1-cycle pulses with 1 high cycle between.
    do_reset();
    base = meas_cnt;
    drive_low(1); cyc(1);
    drive_low(1); cyc(1);
    drive_low(1);
    wait_meas("b2b_meas_timeout", base + 3);
    cyc(5);
    check("b2b_strobes", 64'(meas_cnt - base), 64'd3);
    check("b2b_count", 64'(pulse_count), 64'd3);
    check("b2b_gap", 64'(cap_gap), 64'd1);
    check("b2b_width", 64'(cap_width), 64'd1);
    check("b2b_err_gap", 64'(err_gap), 64'd1);

    // Reset while the line is held low.
    do_reset();
    cyc(20);
    pulse_n = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(3);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_count", 64'(pulse_count), 64'd0);
    rst = 1'b0;
    base = meas_cnt;
    cyc(3);
    check("rst_rel_count", 64'(pulse_count), 64'd1);
    check("rst_rel_busy", 64'(busy), 64'd1);
    cyc(7);
    pulse_n = 1'b1;
    wait_meas("rst_meas_timeout", base + 1);
    check("rst_width", 64'(cap_width), 64'd10);
    check("rst_gv", 64'(cap_gv), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/opk_pulse_monitor.md
# opk_pulse_monitor

Receiving end of the one-shot key pulse line. The block samples the active-low pulse stream that the one-shot generator drives onto LEDS[0], then measures each pulse's width and the gap since the previous pulse. It counts pulses and raises sticky flags when a pulse is too wide or arrives before the minimum dead time has elapsed. It sits beside the generator in the system top and feeds status LEDs and the ILA data bus.

## Interface
- CNT_W, 32: width of the pulse, width and gap counters.
- MIN_GAP, 100: minimum legal number of high cycles between two pulses.
- MAX_WIDTH, 1: maximum legal number of low cycles per pulse.
- SYNC_STAGES, 2: input synchronizer depth, legal range 1..3.
- clk  in  1  single clock. Reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- pulse_n  in  1  monitored line, active low, idle high.
- clr  in  1  one-cycle request that zeroes pulse_count and the sticky error flags.
- pulse_count  out  CNT_W  number of falling edges since reset or clr; wraps modulo 2^CNT_W.
- width_last  out  CNT_W  low-cycle count of the last completed pulse.
- gap_last  out  CNT_W  high-cycle count preceding the last pulse.
- gap_valid  out  1  gap_last refers to a real preceding pulse.
- meas_valid  out  1  one-cycle strobe: width_last, gap_last and gap_valid were just updated.
- err_gap  out  1  sticky: some gap was shorter than MIN_GAP.
- err_width  out  1  sticky: some width exceeded MAX_WIDTH.
- busy  out  1  high while the FSM is in LOW.

## Operation
- Synchronizer: a chain of SYNC_STAGES flops produces s. On rst every flop loads 1, the idle level.
- Edge detection: s_d is s delayed one cycle. fall = s_d & ~s; rise = ~s_d & s.
- FSM states:
  - IDLE: reset state; no pulse seen yet.
  - LOW: line is low; counting width.
  - HIGH: line is high after at least one pulse; counting gap.
- Transitions:
  - IDLE → LOW on fall.
  - LOW → HIGH on rise.
  - HIGH → LOW on fall.
  - No other transitions.
- On fall:
  - Width counter loads 1.
  - pulse_count increments.
  - The gap counter value is latched into a pending-gap register.
  - Pending gap-valid is set to 1 if the source state was HIGH and 0 if it was IDLE.
  - If the source state was HIGH and the gap is below MIN_GAP, err_gap is set.
- In LOW: the width counter increments each cycle and saturates at all-ones.
- On rise:
  - width_last loads the width counter.
  - gap_last and gap_valid load the pending values.
  - meas_valid pulses.
  - err_width is set if the width exceeds MAX_WIDTH.
  - The gap counter loads 1.
- In HIGH: the gap counter increments each cycle and saturates at all-ones.
- Counting rules: width counts cycles of s = 0. Gap counts cycles of s = 1, from the first high cycle through the cycle before fall.
- clr:
  - Zeroes pulse_count, err_gap and err_width.
  - Does not disturb the FSM or measurements in progress.
  - If clr coincides with fall, pulse_count becomes 1.
  - If clr coincides with an error condition, the flag ends set (the event is not lost).
- Reset values:
  - pulse_count = 0, width_last = 0, gap_last = 0.
  - gap_valid = 0, meas_valid = 0, err_gap = 0, err_width = 0, busy = 0.
  - FSM = IDLE; internal counters = 0.
- Reset mid-pulse: the block returns to IDLE. A line still held low then produces a fall after the synchronizer refills, and that is counted as a new first pulse.

## Timing
- From a pulse_n transition to fall/rise being asserted: SYNC_STAGES + 1 cycles.
- pulse_count, busy and err_gap update on the clock edge that ends the fall cycle.
- width_last, gap_last, gap_valid, meas_valid and err_width update on the clock edge that ends the rise cycle.
- meas_valid is high for exactly one cycle per pulse.
- Minimum resolvable pulse: 1 cycle low with 1 cycle high between pulses.
- Back-to-back 1-cycle pulses produce one meas_valid each, with no loss.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package opk_pkg holds:
  - The FSM state encoding (IDLE = 0, LOW = 1, HIGH = 2, 2 bits).
  - The default MIN_GAP = 100.
  - The generator's block length (100), so the generator and the monitor share one constant.
- One sub-module, opk_sync, holds the parameterized synchronizer chain with a reset value of 1. Edge detection, FSM and counters stay in the top module.

## Test plan
- Reset with pulse_n = 1, hold for 50 cycles → every output stays 0 and busy = 0.
- One 1-cycle low pulse after reset → fall is seen at SYNC_STAGES + 1 cycles, with pulse_count = 1. Then meas_valid fires once with width_last = 1, gap_valid = 0, and no errors.
- Two 1-cycle pulses with 150 high cycles between → on the second meas_valid, gap_last = 150, gap_valid = 1, err_gap = 0, pulse_count = 2.
- Two pulses with 40 high cycles between, then a 3-cycle pulse → err_gap = 1 after the second fall. After the third pulse, width_last = 3 and err_width = 1. Then clr → both flags clear and pulse_count = 0.
- clr asserted in the same cycle as fall → pulse_count = 1.
- rst asserted mid-pulse while the line stays low for 10 cycles → after reset release, pulse_count = 1, and the next meas_valid shows gap_valid = 0 with width_last equal to the number of low cycles seen after release.
